// File: rtl/snn_wta_layer.sv
// Temporal-coded spiking layer: one volley per start, first-spike winner-take-all,
// then an optional STDP sweep that updates one neuron's weights per cycle.
module snn_wta_layer #(
    parameter int N_INPUTS  = 8,
    parameter int N_NEURONS = 4,
    parameter int WBITS     = 3,
    parameter int TBITS     = 3,
    parameter int THRESH    = 6,
    parameter int W_INC     = 2,
    parameter int W_DEC     = 1,
    parameter int W_SEARCH  = 1,
    parameter int NB        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    parameter int IB        = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic                      start,
    input  logic                      training,
    input  logic [N_INPUTS-1:0]       spike_en,
    input  logic [N_INPUTS*TBITS-1:0] spike_time,
    input  logic                      wr_en,
    input  logic [NB-1:0]             wr_neuron,
    input  logic [IB-1:0]             wr_input,
    input  logic [WBITS-1:0]          wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      out_spike,
    output logic [TBITS-1:0]          out_time,
    output logic [NB-1:0]             winner,
    output logic [N_NEURONS-1:0]      out_fired
);
    localparam int WMAX = 2**WBITS - 1;
    localparam int PW   = WBITS + $clog2(N_INPUTS);

    typedef enum logic [1:0] {S_IDLE, S_INFER, S_LEARN, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [TBITS-1:0]          t_q, t_d;
    logic [NB-1:0]             k_q, k_d;
    logic                      train_q, train_d;
    logic [N_INPUTS-1:0]       spk_en_q, spk_en_d;
    logic [N_INPUTS*TBITS-1:0] spk_time_q, spk_time_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      out_spike_q, out_spike_d;
    logic [TBITS-1:0]          out_time_q, out_time_d;
    logic [NB-1:0]             winner_q, winner_d;
    logic [N_NEURONS-1:0]      out_fired_q, out_fired_d;
    logic [WBITS-1:0]          w_q [N_NEURONS][N_INPUTS];
    logic [WBITS-1:0]          w_d [N_NEURONS][N_INPUTS];
    logic [N_NEURONS-1:0]      fire;
    logic [NB-1:0]             first;

    function automatic logic [WBITS-1:0] sat_add(input logic [WBITS-1:0] w, input int delta);
        int r;
        r = int'(w) + delta;
        if (r < 0)
            r = 0;
        else if (r > WMAX)
            r = WMAX;
        return r[WBITS-1:0];
    endfunction

    // Potential is the sum of weights of inputs whose spike has already arrived by t.
    genvar gi;
    generate
        for (gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
            logic [PW-1:0] pot;
            always_comb begin
                pot = '0;
                for (int i = 0; i < N_INPUTS; i++) begin
                    if (spk_en_q[i] && (spk_time_q[i*TBITS +: TBITS] <= t_q))
                        pot = pot + PW'(w_q[gi][i]);
                end
            end
            assign fire[gi] = (state_q == S_INFER) && (pot >= PW'(THRESH));
        end
    endgenerate

    always_comb begin
        first = '0;
        for (int n = N_NEURONS - 1; n >= 0; n--) begin
            if (fire[n])
                first = NB'(n);
        end
    end

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        k_d         = k_q;
        train_d     = train_q;
        spk_en_d    = spk_en_q;
        spk_time_d  = spk_time_q;
        out_spike_d = out_spike_q;
        out_time_d  = out_time_q;
        winner_d    = winner_q;
        out_fired_d = out_fired_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    train_d     = training;
                    spk_en_d    = spike_en;
                    spk_time_d  = spike_time;
                    out_spike_d = 1'b0;
                    out_time_d  = '0;
                    winner_d    = '0;
                    out_fired_d = '0;
                    t_d         = '0;
                    state_d     = S_INFER;
                end
            end
            S_INFER: begin
                out_fired_d = out_fired_q | fire;
                if (!out_spike_q && (|fire)) begin
                    out_spike_d = 1'b1;
                    out_time_d  = t_q;
                    winner_d    = first;
                end
                if (t_q == {TBITS{1'b1}}) begin
                    k_d     = '0;
                    state_d = train_q ? S_LEARN : S_DONE;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_LEARN: begin
                if (k_q == NB'(N_NEURONS - 1))
                    state_d = S_DONE;
                else
                    k_d = k_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Learn rule uses the final window results, which are settled before LEARN begins.
    always_comb begin
        w_d = w_q;
        if (state_q == S_IDLE && wr_en)
            w_d[wr_neuron][wr_input] = wr_data;
        if (state_q == S_LEARN) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                if (k_q == NB'(n)) begin
                    for (int i = 0; i < N_INPUTS; i++) begin
                        if (out_spike_q && (winner_q == NB'(n))) begin
                            if (spk_en_q[i] && (spk_time_q[i*TBITS +: TBITS] <= out_time_q))
                                w_d[n][i] = sat_add(w_q[n][i], W_INC);
                            else
                                w_d[n][i] = sat_add(w_q[n][i], -W_DEC);
                        end else if (out_fired_q[n]) begin
                            if (spk_en_q[i])
                                w_d[n][i] = sat_add(w_q[n][i], -W_DEC);
                        end else if (spk_en_q[i]) begin
                            w_d[n][i] = sat_add(w_q[n][i], W_SEARCH);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            k_q         <= '0;
            train_q     <= 1'b0;
            spk_en_q    <= '0;
            spk_time_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_spike_q <= 1'b0;
            out_time_q  <= '0;
            winner_q    <= '0;
            out_fired_q <= '0;
            for (int n = 0; n < N_NEURONS; n++)
                for (int i = 0; i < N_INPUTS; i++)
                    w_q[n][i] <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            k_q         <= k_d;
            train_q     <= train_d;
            spk_en_q    <= spk_en_d;
            spk_time_q  <= spk_time_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_spike_q <= out_spike_d;
            out_time_q  <= out_time_d;
            winner_q    <= winner_d;
            out_fired_q <= out_fired_d;
            w_q         <= w_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_spike = out_spike_q;
    assign out_time  = out_time_q;
    assign winner    = winner_q;
    assign out_fired = out_fired_q;
endmodule

// File: tb/tb_snn_wta_layer.sv
// Self-checking bench for snn_wta_layer: test-plan vectors, protocol corner cases
// and random volleys scored against a window-level reference model.
module tb_snn_wta_layer;
    localparam int NI = 8, NN = 4, TB = 3, TT = 8, WMAX = 7, THRESH = 6;

    logic           clk = 1'b0;
    logic           rst_l = 1'b0;
    logic           start = 1'b0;
    logic           training = 1'b0;
    logic [NI-1:0]  spike_en = '0;
    logic [NI*TB-1:0] spike_time = '0;
    logic           wr_en = 1'b0;
    logic [1:0]     wr_neuron = '0;
    logic [2:0]     wr_input = '0;
    logic [2:0]     wr_data = '0;
    logic           busy, done, out_spike;
    logic [2:0]     out_time;
    logic [1:0]     winner;
    logic [NN-1:0]  out_fired;

    snn_wta_layer dut (
        .clk(clk), .rst_l(rst_l), .start(start), .training(training),
        .spike_en(spike_en), .spike_time(spike_time), .wr_en(wr_en),
        .wr_neuron(wr_neuron), .wr_input(wr_input), .wr_data(wr_data),
        .busy(busy), .done(done), .out_spike(out_spike), .out_time(out_time),
        .winner(winner), .out_fired(out_fired)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wm [NN][NI];

    typedef struct {
        bit               train;
        logic [NI-1:0]    en;
        logic [NI*TB-1:0] tm;
        logic [NN*NI*3-1:0] wl;
        logic             e_spk;
        logic [2:0]       e_t;
        logic [1:0]       e_win;
        logic [NN-1:0]    e_f;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [NI*TB-1:0] tms(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [NI*TB-1:0] r;
        r = {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk) rst_l = 1'b0;
        @(negedge clk) rst_l = 1'b1;
        for (int n = 0; n < NN; n++)
            for (int i = 0; i < NI; i++)
                wm[n][i] = 0;
    endtask

    task automatic write_w(input int n, input int i, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_neuron = 2'(n); wr_input = 3'(i); wr_data = 3'(d);
        @(negedge clk) wr_en = 1'b0;
        wm[n][i] = d;
    endtask

    // Window semantics: walk t, accumulate arrived weights, first crossing wins.
    task automatic model_infer(input logic [NI-1:0] en, input logic [NI*TB-1:0] tm,
                               output logic spk, output int tw, output int win,
                               output logic [NN-1:0] fired);
        spk = 1'b0; tw = 0; win = 0; fired = '0;
        for (int t = 0; t < TT; t++) begin
            bit had;
            had = spk;
            for (int n = 0; n < NN; n++) begin
                int p;
                p = 0;
                for (int i = 0; i < NI; i++)
                    if (en[i] && int'(tm[i*TB +: TB]) <= t) p += wm[n][i];
                if (p >= THRESH) begin
                    fired[n] = 1'b1;
                    if (!had && !spk) begin
                        spk = 1'b1; tw = t; win = n;
                    end
                end
            end
        end
    endtask

    task automatic model_learn(input logic [NI-1:0] en, input logic [NI*TB-1:0] tm,
                               input logic spk, input int tw, input int win,
                               input logic [NN-1:0] fired);
        for (int n = 0; n < NN; n++) begin
            for (int i = 0; i < NI; i++) begin
                int d, v;
                d = 0;
                if (spk && n == win)
                    d = (en[i] && int'(tm[i*TB +: TB]) <= tw) ? 2 : -1;
                else if (fired[n])
                    d = en[i] ? -1 : 0;
                else
                    d = en[i] ? 1 : 0;
                v = wm[n][i] + d;
                wm[n][i] = (v < 0) ? 0 : ((v > WMAX) ? WMAX : v);
            end
        end
    endtask

    task automatic check_weights(input string tag);
        for (int n = 0; n < NN; n++) begin
            logic [NI*3-1:0] act, exp;
            for (int i = 0; i < NI; i++) begin
                act[i*3 +: 3] = dut.w_q[n][i];
                exp[i*3 +: 3] = 3'(wm[n][i]);
            end
            chk($sformatf("%s weights n%0d", tag, n), 32'(act), 32'(exp));
        end
    endtask

    task automatic run(input string tag, input bit tr, input logic [NI-1:0] en,
                       input logic [NI*TB-1:0] tm, output logic a_spk,
                       output logic [2:0] a_t, output logic [1:0] a_w,
                       output logic [NN-1:0] a_f);
        logic e_spk;
        int e_t, e_w, cyc, gaps;
        logic [NN-1:0] e_f;
        bit got;
        model_infer(en, tm, e_spk, e_t, e_w, e_f);
        @(negedge clk);
        training = tr; spike_en = en; spike_time = tm; start = 1'b1;
        @(negedge clk);
        start = 1'b0; spike_en = ~en; spike_time = ~tm; training = ~tr;
        cyc = 1; got = 0; gaps = 0;
        while (cyc < 40) begin
            if (!busy) gaps++;
            if (done) begin
                got = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done_cycle"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(tr ? TT + NN + 1 : TT + 1));
        chk({tag, " busy_gaps"}, 32'(gaps), 32'd0);
        chk({tag, " out_spike"}, 32'(out_spike), 32'(e_spk));
        chk({tag, " out_time"}, 32'(out_time), 32'(e_t));
        chk({tag, " winner"}, 32'(winner), 32'(e_w));
        chk({tag, " out_fired"}, 32'(out_fired), 32'(e_f));
        a_spk = out_spike; a_t = out_time; a_w = winner; a_f = out_fired;
        @(negedge clk);
        chk({tag, " idle_after_done"}, 32'({busy, done}), 32'd0);
        chk({tag, " fired_stable"}, 32'(out_fired), 32'(e_f));
        if (tr) model_learn(en, tm, e_spk, e_t, e_w, e_f);
        check_weights(tag);
        $display("%s train=%0d en=%h tm=%h -> spike=%0d time=%0d winner=%0d fired=%b",
                 tag, tr, en, tm, a_spk, a_t, a_w, a_f);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic a_spk;
        logic [2:0] a_t;
        logic [1:0] a_w;
        logic [NN-1:0] a_f;
        int cyc;

        // Test-plan vectors: preload weights, volley, hand-derived window results.
        for (int k = 0; k < 5; k++) vecs[k].wl = '0;
        vecs[0].train = 0; vecs[0].en = 8'h03; vecs[0].tm = tms(2, 3, 0, 0, 0, 0, 0, 0);
        vecs[0].wl[0*3 +: 3] = 3'd7; vecs[0].wl[1*3 +: 3] = 3'd7;
        vecs[0].e_spk = 1; vecs[0].e_t = 2; vecs[0].e_win = 0; vecs[0].e_f = 4'b0001;
        vecs[1].train = 0; vecs[1].en = 8'h03; vecs[1].tm = tms(1, 4, 0, 0, 0, 0, 0, 0);
        vecs[1].wl[8*3 +: 3] = 3'd3;  vecs[1].wl[9*3 +: 3] = 3'd3;
        vecs[1].wl[16*3 +: 3] = 3'd3; vecs[1].wl[17*3 +: 3] = 3'd3;
        vecs[1].e_spk = 1; vecs[1].e_t = 4; vecs[1].e_win = 1; vecs[1].e_f = 4'b0110;
        vecs[2].train = 1; vecs[2].en = 8'hA5; vecs[2].tm = tms(3, 1, 0, 6, 2, 7, 5, 4);
        vecs[2].e_spk = 0; vecs[2].e_t = 0; vecs[2].e_win = 0; vecs[2].e_f = 4'b0000;
        vecs[3] = vecs[0];
        vecs[3].train = 1; vecs[3].wl[2*3 +: 3] = 3'd3;
        vecs[4].train = 1; vecs[4].en = 8'h0F; vecs[4].tm = tms(1, 1, 3, 3, 0, 0, 0, 0);
        vecs[4].wl[0*3 +: 3] = 3'd7; vecs[4].wl[1*3 +: 3] = 3'd7; vecs[4].wl[10*3 +: 3] = 3'd7;
        vecs[4].e_spk = 1; vecs[4].e_t = 1; vecs[4].e_win = 0; vecs[4].e_f = 4'b0011;

        do_reset();
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset out_spike", 32'(out_spike), 32'd0);
        chk("reset out_time", 32'(out_time), 32'd0);
        chk("reset winner", 32'(winner), 32'd0);
        chk("reset out_fired", 32'(out_fired), 32'd0);
        check_weights("reset");

        for (int k = 0; k < 5; k++) begin
            do_reset();
            for (int n = 0; n < NN; n++)
                for (int i = 0; i < NI; i++)
                    if (vecs[k].wl[(n*NI+i)*3 +: 3] != 3'd0)
                        write_w(n, i, int'(vecs[k].wl[(n*NI+i)*3 +: 3]));
            run($sformatf("vec%0d", k), vecs[k].train, vecs[k].en, vecs[k].tm, a_spk, a_t, a_w, a_f);
            chk($sformatf("vec%0d table spike", k), 32'(a_spk), 32'(vecs[k].e_spk));
            chk($sformatf("vec%0d table time", k), 32'(a_t), 32'(vecs[k].e_t));
            chk($sformatf("vec%0d table winner", k), 32'(a_w), 32'(vecs[k].e_win));
            chk($sformatf("vec%0d table fired", k), 32'(a_f), 32'(vecs[k].e_f));
            if (k == 2) begin
                chk("nospike w[3][7]", 32'(dut.w_q[3][7]), 32'd1);
                chk("nospike w[1][1]", 32'(dut.w_q[1][1]), 32'd0);
            end
            if (k == 3) begin
                chk("stdp w[0][0]", 32'(dut.w_q[0][0]), 32'd7);
                chk("stdp w[0][1]", 32'(dut.w_q[0][1]), 32'd6);
                chk("stdp w[0][2]", 32'(dut.w_q[0][2]), 32'd2);
                chk("stdp w[2][1]", 32'(dut.w_q[2][1]), 32'd1);
            end
            if (k == 4) begin
                chk("backoff w[1][0]", 32'(dut.w_q[1][0]), 32'd0);
                chk("backoff w[1][2]", 32'(dut.w_q[1][2]), 32'd6);
                chk("saturate w[0][1]", 32'(dut.w_q[0][1]), 32'd7);
            end
        end

        // start and wr_en pulsed mid-run must be ignored.
        do_reset();
        write_w(0, 0, 7);
        write_w(0, 1, 7);
        @(negedge clk);
        training = 0; spike_en = 8'h03; spike_time = tms(2, 3, 0, 0, 0, 0, 0, 0); start = 1;
        @(negedge clk) start = 0;
        cyc = 1;
        repeat (2) begin @(negedge clk); cyc++; end
        start = 1; wr_en = 1; wr_neuron = 0; wr_input = 0; wr_data = 0;
        spike_en = 8'hFF; spike_time = '0; training = 1;
        @(negedge clk);
        cyc++;
        start = 0; wr_en = 0;
        while (cyc < 40 && !done) begin @(negedge clk); cyc++; end
        chk("protocol done_cycle", 32'(cyc), 32'(TT + 1));
        chk("protocol out_time", 32'(out_time), 32'd2);
        chk("protocol out_fired", 32'(out_fired), 32'b0001);
        @(negedge clk);
        chk("protocol no_restart", 32'(busy), 32'd0);
        check_weights("protocol");
        $display("protocol: mid-run start/wr_en, done at cycle %0d", cyc);

        // Reset during LEARN cycle 2 discards everything.
        @(negedge clk);
        training = 1; spike_en = 8'h03; spike_time = tms(2, 3, 0, 0, 0, 0, 0, 0); start = 1;
        @(negedge clk) start = 0;
        cyc = 1;
        while (cyc < TT + 2) begin @(negedge clk); cyc++; end
        chk("learn busy", 32'(busy), 32'd1);
        rst_l = 0;
        @(negedge clk);
        rst_l = 1;
        chk("midreset busy_done", 32'({busy, done}), 32'd0);
        chk("midreset outputs", 32'({out_spike, out_time, winner, out_fired}), 32'd0);
        for (int n = 0; n < NN; n++)
            for (int i = 0; i < NI; i++)
                wm[n][i] = 0;
        $display("midreset: reset applied in LEARN cycle 2");
        run("after_reset", 1'b0, 8'hFF, '0, a_spk, a_t, a_w, a_f);

        // Random volleys and weight writes scored against the reference model.
        for (int r = 0; r < 30; r++) begin
            int nw;
            nw = int'($urandom_range(0, 8));
            for (int j = 0; j < nw; j++)
                write_w(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            run($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 8'($urandom),
                24'($urandom), a_spk, a_t, a_w, a_f);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/snn_wta_layer.md
# snn_wta_layer

Parametrised temporal-coded spiking layer with an integrated time base, first-spike winner-take-all and on-chip STDP. One `start` runs one volley through a fixed inference window. With `training` high, a learning sweep follows that updates every neuron's weights, one neuron per cycle. It is the successor to the fixed-size layer: sizes, threshold and STDP step sizes are parameters, and it adds a start/done handshake, a weight-load port and an explicit no-spike result.

## Interface
- N_INPUTS, 8: number of input spike channels
- N_NEURONS, 4: number of neurons; NB = max(1, clog2(N_NEURONS))
- WBITS, 3: weight width; WMAX = 2**WBITS-1
- TBITS, 3: spike-time width; window T_TEST = 2**TBITS cycles
- THRESH, 6: firing threshold, unsigned
- W_INC, 2: capture step
- W_DEC, 1: backoff step
- W_SEARCH, 1: search step
- clk  in  1  clock; all logic on rising edge
- rst_l  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request; accepted only in IDLE
- training  in  1  sampled with start; 1 = run the learn sweep
- spike_en  in  N_INPUTS  per-input spike present; sampled with start
- spike_time  in  N_INPUTS×TBITS  per-input spike time; sampled with start
- wr_en  in  1  weight write; honoured only in IDLE
- wr_neuron  in  NB  write target neuron
- wr_input  in  clog2(N_INPUTS)  write target input
- wr_data  in  WBITS  write data
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at the end of an operation
- out_spike  out  1  some neuron fired in the window
- out_time  out  TBITS  winner fire time; 0 if none
- winner  out  NB  winning neuron; 0 if none
- out_fired  out  N_NEURONS  sticky per-neuron fired flags for the last window

## Operation
- States: IDLE → INFER → (LEARN if training) → DONE → IDLE. DONE lasts exactly one cycle.
- **IDLE:**
  - wr_en writes w[wr_neuron][wr_input] <= wr_data.
  - start latches training, spike_en and spike_time; clears out_fired, out_spike, out_time and winner; sets t = 0.
- **INFER, t = 0..T_TEST-1:**
  - Each neuron's potential is P_n(t) = sum of w[n][i] over inputs with spike_en[i] and spike_time[i] <= t.
  - The sum is computed combinationally from registered weights; the potential width is WBITS+clog2(N_INPUTS), with no overflow.
  - Neuron n fires at t when P_n(t) >= THRESH; out_fired[n] is then set and stays set.
  - The first t at which any neuron fires latches out_spike = 1, out_time = t and winner = lowest-index firing neuron.
  - Later firings never change the winner.
  - The window always runs the full T_TEST cycles, so out_fired is complete.
- **LEARN:** neuron k = 0..N_NEURONS-1 is processed in cycle k. All of neuron k's inputs update in parallel, with saturating arithmetic in [0, WMAX].
  - k is the winner (out_spike = 1): inputs with spike_en and spike_time <= out_time get +W_INC; all other inputs get -W_DEC.
  - k fired but is not the winner: inputs with spike_en get -W_DEC; the rest are unchanged.
  - k did not fire: inputs with spike_en get +W_SEARCH; the rest are unchanged.
- With training = 0, weights never change except through wr_en.
- start while busy is ignored. wr_en while busy is ignored.

## Timing
- Cycle numbering: start is sampled at edge 0; INFER occupies cycles 1..T_TEST.
- LEARN occupies cycles T_TEST+1..T_TEST+N_NEURONS.
- done is high in cycle T_TEST+1 for inference-only runs, and in cycle T_TEST+N_NEURONS+1 for training runs.
- busy is high from cycle 1 through the done cycle inclusive.
- The earliest next start is sampled on the edge ending the done cycle.
- out_* are registered and update within INFER. They are stable from the done cycle until the next accepted start.
- A LEARN weight update is visible from the cycle after its write.
- A wr_en write is visible to an INFER that begins on the following cycle.
- Reset (rst_l low at an edge), also mid-operation:
  - state returns to IDLE;
  - busy, done, out_spike, out_time, winner and out_fired all go to 0;
  - all weights go to 0, and any partial LEARN sweep is discarded.

## Test plan
- **Single winner, inference:** w[0][0] = w[0][1] = 7, all other weights 0; inputs 0@2 and 1@3; training = 0 → out_spike = 1, winner = 0, out_time = 2, out_fired = 0001, done in cycle 9, weights unchanged.
- **Tie:** neurons 1 and 2 loaded with identical weights, all else 0; spike makes both cross at t = 4 → winner = 1, out_time = 4, out_fired = 0110.
- **No spike:** all weights 0, any volley → out_spike = 0, winner = 0, out_time = 0, out_fired = 0; training = 1 → every input with spike_en set goes to 1 in every neuron.
- **STDP:** the first scenario with training = 1, and w[0][2] = 3 preloaded and unspiked →
  - w[0][0] = 7 (saturates), w[0][1] = 6, w[0][2] = 2, other w[0][*] = 0;
  - neurons 1–3: inputs 0 and 1 become 1;
  - done in cycle 13.
- **Backoff and saturation:** neurons 0 and 1 both fire, with 0 first; neuron 1 holds spiked weights of 0 → they stay 0. Neuron 0's spiked weights at 7 stay 7.
- **Protocol:** start and wr_en pulsed in cycle 3 of a run → ignored. rst_l low in LEARN cycle 2 → next cycle is IDLE with all outputs 0, and every weight reads back 0 after a subsequent run.
